// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter: state encoding and width helpers.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Index width for n requesters; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Burst counter width: must be able to hold MAX_BURST itself.
    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst) + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set bit of req scanning from ptr upward, modulo N_REQ.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic             valid,
    output logic [IDW-1:0]   idx
);

    // Scan from the far end back toward ptr so the last hit is the highest-priority one.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N_REQ]) begin
                valid = 1'b1;
                idx   = IDW'((int'(ptr) + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers, with burst lock.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4,
    parameter int IDW       = idx_width(N_REQ)
) (
    input  logic                   clk,
    input  logic                   res,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]       req_last,
    output logic [N_REQ-1:0]       ack,
    output logic                   fifo_wr_en,
    output logic [WIDTH-1:0]       fifo_wdata,
    input  logic                   fifo_full,
    output logic [IDW-1:0]         owner,
    output logic                   busy
);

    localparam int CW = cnt_width(MAX_BURST);

    arb_state_t                    state, state_nx;
    logic [IDW-1:0]                rr_ptr, rr_nx, owner_nx;
    logic [CW-1:0]                 burst_cnt, cnt_nx;
    logic                          pick_vld;
    logic [IDW-1:0]                pick_idx;
    logic [N_REQ-1:0]              ack_raw;
    logic [WIDTH-1:0]              wdata_raw;
    logic [N_REQ-1:0][WIDTH-1:0]   data_arr;

    assign data_arr = req_data;

    function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] i);
        return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    // State, pointer, owner and burst counter; reset drops any lock at once.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            rr_ptr    <= rr_nx;
            owner     <= owner_nx;
            burst_cnt <= cnt_nx;
        end
    end

    // Grant and next-state: full freezes everything; BURST only serves the owner.
    always_comb begin
        ack_raw   = '0;
        wdata_raw = '0;
        state_nx  = state;
        rr_nx     = rr_ptr;
        owner_nx  = owner;
        cnt_nx    = burst_cnt;
        if (!fifo_full) begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        ack_raw[pick_idx] = 1'b1;
                        wdata_raw         = data_arr[pick_idx];
                        if (req_last[pick_idx] || MAX_BURST == 1) begin
                            rr_nx = next_idx(pick_idx);
                        end else begin
                            state_nx = BURST;
                            owner_nx = pick_idx;
                            cnt_nx   = CW'(1);
                        end
                    end
                end
                BURST: begin
                    if (req[owner]) begin
                        ack_raw[owner] = 1'b1;
                        wdata_raw      = data_arr[owner];
                        if (req_last[owner] || (int'(burst_cnt) + 1 == MAX_BURST)) begin
                            state_nx = IDLE;
                            cnt_nx   = '0;
                            rr_nx    = next_idx(owner);
                        end else begin
                            cnt_nx = burst_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are forced low while reset is held, independent of the clock.
    assign ack        = res ? '0 : ack_raw;
    assign fifo_wr_en = |ack;
    assign fifo_wdata = res ? '0 : wdata_raw;
    assign busy       = !res && (state == BURST);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a 16-deep FIFO model and a write scoreboard.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_last = '0;
    logic [3:0]  ack;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wdata;
    logic        fifo_full;
    logic [1:0]  owner;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    // 16-deep FIFO model
    logic [7:0] fmem [16];
    int         fcnt = 0;
    int         fwp  = 0;
    int         frp  = 0;
    logic       ovf  = 1'b0;
    logic       rd_en = 1'b0;
    logic       force_full = 1'b0;

    assign fifo_full = (fcnt == 16) || force_full;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .N_REQ     (4),
        .WIDTH     (8),
        .MAX_BURST (4)
    ) dut (
        .clk        (clk),
        .res        (res),
        .req        (req),
        .req_data   (req_data),
        .req_last   (req_last),
        .ack        (ack),
        .fifo_wr_en (fifo_wr_en),
        .fifo_wdata (fifo_wdata),
        .fifo_full  (fifo_full),
        .owner      (owner),
        .busy       (busy)
    );

    always @(posedge clk) begin
        if (fifo_wr_en) begin
            if (fcnt == 16) ovf <= 1'b1;
            else begin
                fmem[fwp] <= fifo_wdata;
                fwp       <= (fwp + 1) % 16;
            end
        end
        if (rd_en && fcnt > 0) frp <= (frp + 1) % 16;
        fcnt <= fcnt + ((fifo_wr_en && fcnt < 16) ? 1 : 0) - ((rd_en && fcnt > 0) ? 1 : 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write must match the next expected word.
    always @(negedge clk) begin
        if (fifo_wr_en) begin
            if (exp_q.size() == 0) chk("sb_unexpected_write", {24'b0, fifo_wdata}, 32'hFFFF_FFFF);
            else                   chk("sb_wdata", {24'b0, fifo_wdata}, {24'b0, exp_q.pop_front()});
        end
    end

    task automatic drive(input logic [3:0] r, input logic [3:0] l, input logic [31:0] d);
        req      = r;
        req_last = l;
        req_data = d;
    endtask

    // One cycle: push expected word if a grant is expected, check at negedge, advance.
    task automatic step(input string tag, input logic [3:0] eack, input logic ebusy, input logic [7:0] ed);
        if (eack != 4'b0) exp_q.push_back(ed);
        @(negedge clk);
        chk({tag, "_ack"}, {28'b0, ack}, {28'b0, eack});
        chk({tag, "_wr"}, {31'b0, fifo_wr_en}, {31'b0, |eack});
        chk({tag, "_busy"}, {31'b0, busy}, {31'b0, ebusy});
        @(posedge clk); #1;
    endtask

    task automatic fpop(input logic [7:0] e);
        @(negedge clk);
        chk("fifo_nonempty", {31'b0, fcnt > 0}, 32'd1);
        chk("fifo_rd", {24'b0, fmem[frp]}, {24'b0, e});
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
    endtask

    initial begin
        // reset state, with requests present
        drive(4'b1111, 4'b1111, 32'hA3A2A1A0);
        @(posedge clk); #1;
        step("rst", 4'b0000, 1'b0, 8'h00);
        chk("rst_owner", {30'b0, owner}, 32'd0);
        res = 1'b0;
        drive(4'b0000, 4'b0000, 32'h0);
        @(posedge clk); #1;

        // 1: reset mid-burst (owner 2, burst_cnt 2)
        drive(4'b0100, 4'b0000, 32'h0020_0000);
        step("t1a", 4'b0100, 1'b0, 8'h20);
        drive(4'b0100, 4'b0000, 32'h0021_0000);
        step("t1b", 4'b0100, 1'b1, 8'h21);
        chk("t1_owner", {30'b0, owner}, 32'd2);
        res = 1'b1;
        #1;
        chk("t1_rst_ack", {28'b0, ack}, 32'd0);
        chk("t1_rst_wr", {31'b0, fifo_wr_en}, 32'd0);
        chk("t1_rst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        res = 1'b0;
        drive(4'b0101, 4'b0001, 32'h0022_0005);
        step("t1c", 4'b0001, 1'b0, 8'h05);
        drive(4'b0000, 4'b0000, 32'h0);
        fpop(8'h20); fpop(8'h21); fpop(8'h05);
        drive(4'b1000, 4'b1000, 32'h3300_0000);
        step("t1d", 4'b1000, 1'b0, 8'h33);
        drive(4'b0000, 4'b0000, 32'h0);
        fpop(8'h33);

        // 2: plain round robin, single-word bursts
        drive(4'b1111, 4'b1111, 32'hA3A2A1A0);
        step("t2a", 4'b0001, 1'b0, 8'hA0);
        drive(4'b1110, 4'b1111, 32'hA3A2A1A0);
        step("t2b", 4'b0010, 1'b0, 8'hA1);
        drive(4'b1100, 4'b1111, 32'hA3A2A1A0);
        step("t2c", 4'b0100, 1'b0, 8'hA2);
        drive(4'b1000, 4'b1111, 32'hA3A2A1A0);
        step("t2d", 4'b1000, 1'b0, 8'hA3);
        drive(4'b0000, 4'b0000, 32'h0);
        fpop(8'hA0); fpop(8'hA1); fpop(8'hA2); fpop(8'hA3);

        // 3: burst with contention from requester 1
        drive(4'b0011, 4'b0010, 32'h0000_4010);
        step("t3a", 4'b0001, 1'b0, 8'h10);
        drive(4'b0011, 4'b0010, 32'h0000_4011);
        step("t3b", 4'b0001, 1'b1, 8'h11);
        drive(4'b0011, 4'b0011, 32'h0000_4012);
        step("t3c", 4'b0001, 1'b1, 8'h12);
        drive(4'b0010, 4'b0010, 32'h0000_4000);
        step("t3d", 4'b0010, 1'b0, 8'h40);
        drive(4'b0000, 4'b0000, 32'h0);
        fpop(8'h10); fpop(8'h11); fpop(8'h12); fpop(8'h40);

        // 4: forced release after MAX_BURST words
        drive(4'b1100, 4'b1000, 32'h7060_0000);
        step("t4a", 4'b0100, 1'b0, 8'h60);
        drive(4'b1100, 4'b1000, 32'h7061_0000);
        step("t4b", 4'b0100, 1'b1, 8'h61);
        drive(4'b1100, 4'b1000, 32'h7062_0000);
        step("t4c", 4'b0100, 1'b1, 8'h62);
        drive(4'b1100, 4'b1000, 32'h7063_0000);
        step("t4d", 4'b0100, 1'b1, 8'h63);
        drive(4'b1100, 4'b1000, 32'h7064_0000);
        step("t4e", 4'b1000, 1'b0, 8'h70);
        drive(4'b0100, 4'b0000, 32'h0064_0000);
        step("t4f", 4'b0100, 1'b0, 8'h64);
        drive(4'b0100, 4'b0100, 32'h0065_0000);
        step("t4g", 4'b0100, 1'b1, 8'h65);
        drive(4'b0000, 4'b0000, 32'h0);
        fpop(8'h60); fpop(8'h61); fpop(8'h62); fpop(8'h63);
        fpop(8'h70); fpop(8'h64); fpop(8'h65);

        // 5: full blocks grants without side effects
        force_full = 1'b1;
        drive(4'b0010, 4'b0010, 32'h0000_5000);
        step("t5a", 4'b0000, 1'b0, 8'h00);
        step("t5b", 4'b0000, 1'b0, 8'h00);
        step("t5c", 4'b0000, 1'b0, 8'h00);
        force_full = 1'b0;
        step("t5d", 4'b0010, 1'b0, 8'h50);
        drive(4'b0000, 4'b0000, 32'h0);
        chk("t5_ovf", {31'b0, ovf}, 32'd0);
        fpop(8'h50);

        // 6: owner gap keeps the lock and the count
        drive(4'b0001, 4'b0000, 32'h0000_0080);
        step("t6a", 4'b0001, 1'b0, 8'h80);
        drive(4'b1000, 4'b1000, 32'h9000_0000);
        step("t6g1", 4'b0000, 1'b1, 8'h00);
        step("t6g2", 4'b0000, 1'b1, 8'h00);
        chk("t6_owner", {30'b0, owner}, 32'd0);
        drive(4'b1001, 4'b1000, 32'h9000_0081);
        step("t6b", 4'b0001, 1'b1, 8'h81);
        drive(4'b1001, 4'b1000, 32'h9000_0082);
        step("t6c", 4'b0001, 1'b1, 8'h82);
        drive(4'b1001, 4'b1000, 32'h9000_0083);
        step("t6d", 4'b0001, 1'b1, 8'h83);
        drive(4'b1001, 4'b1001, 32'h9000_0084);
        step("t6e", 4'b1000, 1'b0, 8'h90);
        drive(4'b0001, 4'b0001, 32'h0000_0084);
        step("t6f", 4'b0001, 1'b0, 8'h84);
        drive(4'b0000, 4'b0000, 32'h0);
        fpop(8'h80); fpop(8'h81); fpop(8'h82); fpop(8'h83);
        fpop(8'h90); fpop(8'h84);

        @(negedge clk);
        chk("end_fifo_empty", fcnt, 32'd0);
        chk("end_ovf", {31'b0, ovf}, 32'd0);
        chk("end_sb_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that lets N producers share the single write port of one synchronous FIFO. It accepts per-requester write requests and drives the FIFO's wr_en/wdata. It honours FIFO full, so no overflow is ever caused. Supports burst lock: a requester keeps the port until it signals last, or until MAX_BURST words have been written.

Parameters:
N_REQ, 4, number of requesters (>=2)
WIDTH, 8, data width; must match the FIFO's WIDTH
MAX_BURST, 4, maximum words per lock before a forced release (>=1; 1 disables locking)
IDW, $clog2(N_REQ), derived index width

Ports:
clk  in  1  clock, rising edge
res  in  1  reset; asynchronous, active-high
req  in  N_REQ  per-requester write request; req[i] and its data/last are held stable until ack[i]
req_data  in  N_REQ*WIDTH  packed data; requester i occupies bits [i*WIDTH +: WIDTH]
req_last  in  N_REQ  high means this word ends requester i's burst
ack  out  N_REQ  one-hot; word from requester i is written this cycle
fifo_wr_en  out  1  to FIFO wr_en
fifo_wdata  out  WIDTH  to FIFO wdata
fifo_full  in  1  from FIFO full
owner  out  IDW  index of the current burst owner (valid when busy=1)
busy  out  1  1 while in state BURST

Behaviour:
- State registers: state {IDLE, BURST}, rr_ptr[IDW], owner[IDW], burst_cnt (width $clog2(MAX_BURST)+1).
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, owner=0, burst_cnt=0.
- While res=1: ack=0, fifo_wr_en=0, fifo_wdata=0, busy=0.
- ack and fifo_wr_en are combinational from the current state, req and fifo_full, so there is zero-cycle latency from request to write.
- fifo_full=1: ack=0 and fifo_wr_en=0. No state, pointer or counter changes that cycle.
- IDLE:
  - Winner w = first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - No request: nothing happens.
  - Otherwise ack[w]=1, fifo_wr_en=1, fifo_wdata=req_data[w].
  - If req_last[w]=1 or MAX_BURST=1: stay in IDLE, rr_ptr <= (w+1) mod N_REQ.
  - Else: go to BURST, owner <= w, burst_cnt <= 1.
- BURST:
  - Only owner is eligible; all other requests are ignored.
  - If req[owner]=0: wait. No grant, busy stays 1; there is no timeout.
  - If req[owner]=1 and not full: ack[owner]=1 and the word is written, then burst_cnt++.
  - If req_last[owner]=1 or burst_cnt+1==MAX_BURST: state <= IDLE, burst_cnt <= 0, rr_ptr <= (owner+1) mod N_REQ.
- Wrap-around: rr_ptr and the scan use explicit modulo N_REQ, which is correct for non-power-of-two N_REQ.
- Forced release does not drop data. The requester keeps req high and re-competes in round-robin order; its next word starts a new lock.
- At most one ack bit is ever high, and fifo_wr_en == |ack.
- This block never writes while fifo_full=1, so FIFO overflow stays 0.
- Reset mid-burst: lock lost immediately, outputs go low asynchronously, and the partial burst is the requester's concern.

Decomposition:
- Package fifo_arb_pkg holds the state encoding constants (IDLE=0, BURST=1) and the IDW / burst counter width helper functions.
- Sub-module rr_pick: combinational rotating-priority encoder.
  - Inputs: req[N_REQ], ptr[IDW].
  - Outputs: valid, idx[IDW].
  - Instantiated once.
- The rest (FSM, counters, data mux) lives in the top module.

Test Plan (N_REQ=4, WIDTH=8, MAX_BURST=4, bench connects a real 16-deep FIFO):
1. Assert res mid-BURST (owner=2, burst_cnt=2) -> same cycle: ack=0000, fifo_wr_en=0, busy=0. After release: rr_ptr=0, a req=0001 is granted to requester 0.
2. req=1111, req_last=1111, data 0xA0..0xA3, not full -> acks 0001, 0010, 0100, 1000 on 4 consecutive cycles. FIFO reads back A0, A1, A2, A3.
3. Burst with contention:
   - Stimulus: req0 sends 3 words (last=0,0,1), data 0x10..0x12; req1 is held high from cycle 0.
   - Response: ack[0] on cycles 0-2, busy=1 on cycles 1-2, ack[1] on cycle 3.
4. Forced release:
   - Stimulus: req2 streams 6 words with last=0 except word 6; req3 is pending.
   - Response: 4 acks to requester 2, then ack[3], then requester 2 resumes for 2 more words.
   - FIFO order: 2,2,2,2,3,2,2.
5. fifo_full=1 with req=0010 for 3 cycles -> ack=0, fifo_wr_en=0, rr_ptr unchanged, FIFO overflow stays 0. Drop full -> ack=0010 in that same cycle.
6. Owner gap: owner=0 in BURST drops req for 2 cycles while req3=1 -> no acks, busy=1. Req0 returns -> ack[0], burst continues with burst_cnt preserved.
